// File: rtl/raster_scan_gen_if.sv
// Control/status bundle between a raster scanner and its consumer.
// The master drives the run controls and observes timing; the slave is the scanner.
interface raster_scan_gen_if #(
  parameter int CW = 10,
  parameter int FW = 8
);
  logic          en_i;
  logic          oneshot_i;
  logic          start_i;
  logic [CW-1:0] X_o;
  logic [CW-1:0] Y_o;
  logic          de_o;
  logic          hsync_o;
  logic          vsync_o;
  logic          sof_o;
  logic          OVF_o;
  logic          busy_o;
  logic [FW-1:0] frame_cnt_o;

  modport master (
    output en_i, oneshot_i, start_i,
    input  X_o, Y_o, de_o, hsync_o, vsync_o, sof_o, OVF_o, busy_o, frame_cnt_o
  );

  modport slave (
    input  en_i, oneshot_i, start_i,
    output X_o, Y_o, de_o, hsync_o, vsync_o, sof_o, OVF_o, busy_o, frame_cnt_o
  );
endinterface

// File: rtl/raster_scan_gen.sv
// Parametrised raster scanner: walks every pixel of a frame including blanking,
// with free-run and one-shot modes. All outputs registered, decoded from next state.
module raster_scan_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  raster_scan_gen_if.slave  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_cw_chk
    $error("raster_scan_gen: CW too small for H_TOTAL/V_TOTAL");
  end
  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_zero_chk
    $error("raster_scan_gen: H_ACTIVE, H_SYNC, V_ACTIVE and V_SYNC must be non-zero");
  end

  localparam logic [CW-1:0] HT_M1 = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] VT_M1 = CW'(V_TOTAL - 1);
  // Region bounds one bit wider: the sync end may equal 2^CW when back porch is 0.
  localparam logic [CW:0] HA_W  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] VA_W  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HSB_W = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HSE_W = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VSB_W = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VSE_W = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        st_q, st_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic          sof_q, sof_d, ovf_q, ovf_d, busy_q, busy_d;
  logic          adv, run_d, hs_act, vs_act;
  logic [CW:0]   xw, yw;

  always_comb begin
    st_d   = st_q;
    x_d    = x_q;
    y_d    = y_q;
    fcnt_d = fcnt_q;
    pend_d = pend_q;
    sof_d  = 1'b0;
    adv    = 1'b0;
    case (st_q)
      IDLE: begin
        // A start seen while en is low is remembered until the pixel clock allows launch.
        if (bus.en_i && (!bus.oneshot_i || bus.start_i || pend_q)) begin
          st_d   = RUN;
          x_d    = '0;
          y_d    = '0;
          sof_d  = 1'b1;
          adv    = 1'b1;
          pend_d = 1'b0;
        end else if (bus.oneshot_i && bus.start_i) begin
          pend_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.en_i) begin
          adv = 1'b1;
          if (x_q == HT_M1 && y_q == VT_M1) begin
            fcnt_d = fcnt_q + FW'(1);
            x_d    = '0;
            y_d    = '0;
            if (bus.oneshot_i) st_d  = IDLE;
            else               sof_d = 1'b1;
          end else if (x_q == HT_M1) begin
            x_d = '0;
            y_d = y_q + CW'(1);
          end else begin
            x_d = x_q + CW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase

    run_d  = (st_d == RUN);
    xw     = {1'b0, x_d};
    yw     = {1'b0, y_d};
    hs_act = run_d && (xw >= HSB_W) && (xw < HSE_W);
    vs_act = run_d && (yw >= VSB_W) && (yw < VSE_W);
    de_d   = run_d && (xw < HA_W) && (yw < VA_W);
    hs_d   = hs_act ? HS_POL : ~HS_POL;
    vs_d   = vs_act ? VS_POL : ~VS_POL;
    ovf_d  = adv && run_d && (x_d == HT_M1) && (y_d == VT_M1);
    busy_d = run_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      fcnt_q <= '0;
      pend_q <= 1'b0;
      de_q   <= 1'b0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      sof_q  <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fcnt_q <= fcnt_d;
      pend_q <= pend_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      sof_q  <= sof_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
    end
  end

  assign bus.X_o         = x_q;
  assign bus.Y_o         = y_q;
  assign bus.de_o        = de_q;
  assign bus.hsync_o     = hs_q;
  assign bus.vsync_o     = vs_q;
  assign bus.sof_o       = sof_q;
  assign bus.OVF_o       = ovf_q;
  assign bus.busy_o      = busy_q;
  assign bus.frame_cnt_o = fcnt_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// Directed bench for raster_scan_gen on an 8x6 total raster (4x3 active).
module tb_raster_scan_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  raster_scan_gen_if #(.CW(3), .FW(2)) bus ();

  raster_scan_gen #(
    .CW(3), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FW(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected timing for pixel index p in the 8x6 raster.
  task automatic chk_pix(input int p, input bit sof_e, input bit ovf_e);
    int x, y;
    x = p % 8;
    y = p / 8;
    chk($sformatf("X@%0d", p), bus.X_o, x);
    chk($sformatf("Y@%0d", p), bus.Y_o, y);
    chk($sformatf("de@%0d", p), bus.de_o, (x < 4 && y < 3) ? 1 : 0);
    chk($sformatf("hsync@%0d", p), bus.hsync_o, (x == 5 || x == 6) ? 0 : 1);
    chk($sformatf("vsync@%0d", p), bus.vsync_o, (y == 4) ? 0 : 1);
    chk($sformatf("sof@%0d", p), bus.sof_o, sof_e);
    chk($sformatf("ovf@%0d", p), bus.OVF_o, ovf_e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_X"}, bus.X_o, 0);
    chk({tag, "_Y"}, bus.Y_o, 0);
    chk({tag, "_de"}, bus.de_o, 0);
    chk({tag, "_sof"}, bus.sof_o, 0);
    chk({tag, "_ovf"}, bus.OVF_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_hs"}, bus.hsync_o, 1);
    chk({tag, "_vs"}, bus.vsync_o, 1);
    chk({tag, "_fcnt"}, bus.frame_cnt_o, 0);
  endtask

  initial begin
    int de_cnt, sofs, ovfs;
    bus.en_i = 1'b0;
    bus.oneshot_i = 1'b0;
    bus.start_i = 1'b0;

    step(2);
    chk_reset_vals("rst");

    // free-run, first frame
    @(negedge clk);
    rst = 1'b1;
    bus.en_i = 1'b1;
    step(1);
    chk("busy_run", bus.busy_o, 1);
    de_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      chk_pix(k, k == 0, k == 47);
      de_cnt += int'(bus.de_o);
      if (k == 47) chk("fcnt_at_ovf", bus.frame_cnt_o, 0);
      step(1);
    end
    chk("de_per_frame", de_cnt, 12);
    chk_pix(0, 1, 0);
    chk("fcnt_f1", bus.frame_cnt_o, 1);

    // frame counter wrap
    for (int f = 0; f < 4; f++) begin
      step(47);
      chk("wrap_ovf", bus.OVF_o, 1);
      chk("wrap_fcnt_pre", bus.frame_cnt_o, (1 + f) % 4);
      step(1);
      chk("wrap_sof", bus.sof_o, 1);
      chk("wrap_fcnt", bus.frame_cnt_o, (2 + f) % 4);
    end

    // en toggling: a frame spans 96 clocks, pulses stay single-cycle
    sofs = 0;
    ovfs = 0;
    for (int c = 1; c <= 96; c++) begin
      bus.en_i = (c % 2 == 0);
      step(1);
      chk($sformatf("tog_X@%0d", c), bus.X_o, ((c / 2) % 48) % 8);
      chk($sformatf("tog_Y@%0d", c), bus.Y_o, ((c / 2) % 48) / 8);
      chk($sformatf("tog_ovf@%0d", c), bus.OVF_o, (c == 94) ? 1 : 0);
      sofs += int'(bus.sof_o);
      ovfs += int'(bus.OVF_o);
    end
    chk("tog_sof_cnt", sofs, 1);
    chk("tog_ovf_cnt", ovfs, 1);
    chk("tog_sof_end", bus.sof_o, 1);
    chk("tog_fcnt", bus.frame_cnt_o, 2);
    bus.en_i = 1'b1;

    // switch to one-shot at (2,3): frame finishes, then idle
    step(26);
    chk("mc_X", bus.X_o, 2);
    chk("mc_Y", bus.Y_o, 3);
    bus.oneshot_i = 1'b1;
    step(21);
    chk_pix(47, 0, 1);
    step(1);
    chk_reset_vals_idle("mc_idle", 3);
    step(5);
    chk_reset_vals_idle("mc_idle2", 3);

    // one-shot launch; a second start mid-frame is ignored
    bus.start_i = 1'b1;
    step(1);
    bus.start_i = 1'b0;
    chk_pix(0, 1, 0);
    chk("os_busy", bus.busy_o, 1);
    step(10);
    bus.start_i = 1'b1;
    step(1);
    bus.start_i = 1'b0;
    chk_pix(11, 0, 0);
    step(36);
    chk_pix(47, 0, 1);
    step(1);
    chk_reset_vals_idle("os_idle", 0);
    step(6);
    chk_reset_vals_idle("os_idle2", 0);

    // async reset mid-frame at (3,1) of the second free-run frame
    bus.oneshot_i = 1'b0;
    step(1);
    chk_pix(0, 1, 0);
    step(48);
    chk("ar_fcnt_pre", bus.frame_cnt_o, 1);
    step(11);
    chk("ar_X", bus.X_o, 3);
    chk("ar_Y", bus.Y_o, 1);
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("ar");
    @(negedge clk);
    rst = 1'b1;
    step(1);
    chk_pix(0, 1, 0);
    chk("ar_busy", bus.busy_o, 1);
    chk("ar_fcnt", bus.frame_cnt_o, 0);

    // one-shot from reset stays idle
    rst = 1'b0;
    bus.oneshot_i = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk_reset_vals("os_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic chk_reset_vals_idle(input string tag, input int fcnt_e);
    chk({tag, "_X"}, bus.X_o, 0);
    chk({tag, "_Y"}, bus.Y_o, 0);
    chk({tag, "_de"}, bus.de_o, 0);
    chk({tag, "_sof"}, bus.sof_o, 0);
    chk({tag, "_ovf"}, bus.OVF_o, 0);
    chk({tag, "_busy"}, bus.busy_o, 0);
    chk({tag, "_hs"}, bus.hsync_o, 1);
    chk({tag, "_vs"}, bus.vsync_o, 1);
    chk({tag, "_fcnt"}, bus.frame_cnt_o, fcnt_e);
  endtask

endmodule
